// File: rtl/minibus_master_port.sv
// Mini-Bus initiator: accepts one core load/store, checks alignment, drives the bus until ack,
// then returns lane-extracted read data. Optional REQ timeout under MINIBUS_MASTER_TIMEOUT_EN.
module minibus_master_port #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req_valid,
  output logic                  core_req_ready,
  input  logic                  core_wen,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  input  logic [1:0]            core_width,
  input  logic                  core_signed,
  output logic                  core_resp_valid,
  output logic [DATA_WIDTH-1:0] core_resp_rdata,
  output logic                  core_resp_err,
  output logic                  core_resp_timeout,
  output logic                  bus_wen,
  output logic                  bus_ren,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [1:0]            bus_width,
  input  logic                  bus_ack,
  input  logic                  bus_err,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e                state_q, state_d;
  logic                  bus_wen_q, bus_wen_d;
  logic                  bus_ren_q, bus_ren_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [1:0]            bus_width_q, bus_width_d;
  logic                  signed_q, signed_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] lane_data;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic                  illegal;

`ifdef MINIBUS_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_timeout_q, resp_timeout_d;
`endif

  assign illegal = (core_width == 2'b11) ||
                   (core_width == 2'b01 && core_addr[0]) ||
                   (core_width == 2'b10 && core_addr[1:0] != 2'b00);

  // Slaves return the whole word; pick the addressed lane and extend it.
  assign lane_byte = bus_rdata[{bus_addr_q[1:0], 3'b000} +: 8];
  assign lane_half = bus_rdata[{bus_addr_q[1], 4'b0000} +: 16];

  always_comb begin
    case (bus_width_q)
      2'b00:   lane_data = {{(DATA_WIDTH-8){signed_q & lane_byte[7]}}, lane_byte};
      2'b01:   lane_data = {{(DATA_WIDTH-16){signed_q & lane_half[15]}}, lane_half};
      default: lane_data = bus_rdata;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d      = state_q;
    bus_wen_d    = bus_wen_q;
    bus_ren_d    = bus_ren_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_width_d  = bus_width_q;
    signed_d     = signed_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
`ifdef MINIBUS_MASTER_TIMEOUT_EN
    cnt_d          = cnt_q;
    resp_timeout_d = resp_timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (core_req_valid) begin
          bus_addr_d   = core_addr;
          bus_wdata_d  = core_wdata;
          bus_width_d  = core_width;
          signed_d     = core_signed;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
`ifdef MINIBUS_MASTER_TIMEOUT_EN
          cnt_d          = '0;
          resp_timeout_d = 1'b0;
`endif
          if (illegal) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d   = REQ;
            bus_wen_d = core_wen;
            bus_ren_d = ~core_wen;
          end
        end
      end
      REQ: begin
        if (bus_ack) begin
          state_d      = RESP;
          bus_wen_d    = 1'b0;
          bus_ren_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = bus_err;
          resp_rdata_d = (bus_err || bus_wen_q) ? '0 : lane_data;
        end
`ifdef MINIBUS_MASTER_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          // The count after this cycle would hit the limit: abort now so the bus saw exactly N cycles.
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d        = RESP;
            bus_wen_d      = 1'b0;
            bus_ren_d      = 1'b0;
            resp_valid_d   = 1'b1;
            resp_err_d     = 1'b1;
            resp_timeout_d = 1'b1;
          end
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bus_wen_q    <= 1'b0;
      bus_ren_q    <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_width_q  <= 2'b00;
      signed_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_wen_q    <= bus_wen_d;
      bus_ren_q    <= bus_ren_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_width_q  <= bus_width_d;
      signed_q     <= signed_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

`ifdef MINIBUS_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      resp_timeout_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end
  assign core_resp_timeout = resp_timeout_q;
`else
  assign core_resp_timeout = 1'b0;
`endif

  assign core_req_ready  = (state_q == IDLE);
  assign core_resp_valid = resp_valid_q;
  assign core_resp_rdata = resp_rdata_q;
  assign core_resp_err   = resp_err_q;
  assign bus_wen         = bus_wen_q;
  assign bus_ren         = bus_ren_q;
  assign bus_addr        = bus_addr_q;
  assign bus_wdata       = bus_wdata_q;
  assign bus_width       = bus_width_q;

endmodule

// File: tb/tb_minibus_master_port.sv
// Self-checking bench for minibus_master_port: registered word slave with wait states and
// error injection, and a word-array reference model for expected responses.
module tb_minibus_master_port;

  localparam int TMO = 4;

  logic        clk, rst;
  logic        core_req_valid, core_req_ready, core_wen, core_signed;
  logic [31:0] core_addr, core_wdata, core_resp_rdata;
  logic [1:0]  core_width;
  logic        core_resp_valid, core_resp_err, core_resp_timeout;
  logic        bus_wen, bus_ren, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [1:0]  bus_width;

  int checks = 0;
  int failures = 0;

  minibus_master_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_wen(core_wen), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_width(core_width), .core_signed(core_signed),
    .core_resp_valid(core_resp_valid), .core_resp_rdata(core_resp_rdata),
    .core_resp_err(core_resp_err), .core_resp_timeout(core_resp_timeout),
    .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_width(bus_width), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered slave: acks W+1 cycles after the enable is first seen, and keeps acking while enabled.
  logic [31:0] smem [16];
  int          s_wait = 0;
  int          s_cnt;
  logic        s_en = 1'b1;
  logic        s_err = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_ack <= 1'b0; bus_err <= 1'b0; bus_rdata <= '0; s_cnt <= 0;
    end else begin
      bus_ack <= 1'b0;
      bus_err <= 1'b0;
      if (s_en && (bus_ren || bus_wen)) begin
        if (s_cnt >= s_wait) begin
          bus_ack   <= 1'b1;
          bus_err   <= s_err;
          bus_rdata <= smem[bus_addr[5:2]];
          if (bus_wen && !s_err) smem[bus_addr[5:2]] <= bus_wdata;
        end else begin
          s_cnt <= s_cnt + 1;
        end
      end else begin
        s_cnt <= 0;
      end
    end
  end

  int mon_ren = 0, mon_wen = 0, mon_resp = 0;
  always @(negedge clk) begin
    if (bus_ren) mon_ren <= mon_ren + 1;
    if (bus_wen) mon_wen <= mon_wen + 1;
    if (core_resp_valid) mon_resp <= mon_resp + 1;
  end

  logic [31:0] ref_mem [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic txn(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] wd, input logic s);
    logic        illegal, exp_err, exp_to;
    logic [31:0] word, v, exp_rd, rd;
    logic        er, to;
    int          exp_lat, exp_bus, lat, r0, w0, p0;

    illegal = (wd == 2'd3) || (wd == 2'd1 && a[0]) || (wd == 2'd2 && a[1:0] != 2'd0);
    word    = ref_mem[a[5:2]];
    exp_rd  = 32'h0;
    exp_err = 1'b0;
    exp_to  = 1'b0;
    if (illegal) begin
      exp_err = 1'b1; exp_lat = 1; exp_bus = 0;
    end else if (!s_en) begin
      exp_err = 1'b1; exp_to = 1'b1; exp_lat = TMO + 1; exp_bus = TMO;
    end else begin
      exp_lat = 3 + s_wait;
      exp_bus = 2 + s_wait;
      if (s_err) exp_err = 1'b1;
      else if (!w) begin
        case (wd)
          2'd0: begin v = (word >> (8 * a[1:0])) & 32'hFF;
                      if (s && v >= 32'h80) v = v | 32'hFFFF_FF00; end
          2'd1: begin v = (word >> (16 * a[1])) & 32'hFFFF;
                      if (s && v >= 32'h8000) v = v | 32'hFFFF_0000; end
          default: v = word;
        endcase
        exp_rd = v;
      end
    end

    @(negedge clk);
    #1;
    check({tag, " ready"}, 32'(core_req_ready), 32'd1);
    r0 = mon_ren; w0 = mon_wen; p0 = mon_resp;
    core_req_valid = 1'b1; core_wen = w; core_addr = a; core_wdata = d;
    core_width = wd; core_signed = s;
    @(posedge clk);
    #1;
    core_req_valid = 1'b0;
    lat = 0; rd = 'x; er = 'x; to = 'x;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (core_resp_valid) begin
        lat = i; rd = core_resp_rdata; er = core_resp_err; to = core_resp_timeout;
        break;
      end
    end
    repeat (3) @(negedge clk);
    #1;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rdata"}, rd, exp_rd);
    check({tag, " err"}, 32'(er), 32'(exp_err));
    check({tag, " timeout"}, 32'(to), 32'(exp_to));
    check({tag, " ren_cycles"}, 32'(mon_ren - r0), w ? 32'd0 : 32'(exp_bus));
    check({tag, " wen_cycles"}, 32'(mon_wen - w0), w ? 32'(exp_bus) : 32'd0);
    check({tag, " resp_pulses"}, 32'(mon_resp - p0), 32'd1);
    if (!illegal && s_en && !s_err && w) ref_mem[a[5:2]] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst = 1'b1;
    core_req_valid = 1'b0; core_wen = 1'b0; core_addr = '0; core_wdata = '0;
    core_width = 2'b00; core_signed = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ready", 32'(core_req_ready), 32'd1);
    check("reset resp_valid", 32'(core_resp_valid), 32'd0);
    check("reset resp_err", 32'(core_resp_err), 32'd0);
    check("reset resp_timeout", 32'(core_resp_timeout), 32'd0);
    check("reset bus_en", {30'd0, bus_ren, bus_wen}, 32'd0);
    check("reset bus_addr", bus_addr, 32'd0);
    check("reset resp_rdata", core_resp_rdata, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) txn("init_wr", 1'b1, 32'(i * 4), $urandom, 2'd2, 1'b0);

    txn("wr_word_4", 1'b1, 32'h4, 32'hDEAD_BEEF, 2'd2, 1'b0);
    txn("rd_word_4", 1'b0, 32'h4, 32'h0, 2'd2, 1'b0);
    txn("wr_word_8", 1'b1, 32'h8, 32'h80FF_7F01, 2'd2, 1'b0);
    txn("rd_byte3_s", 1'b0, 32'hB, 32'h0, 2'd0, 1'b1);
    txn("rd_byte3_u", 1'b0, 32'hB, 32'h0, 2'd0, 1'b0);
    txn("rd_half2_s", 1'b0, 32'hA, 32'h0, 2'd1, 1'b1);
    txn("rd_byte0_s", 1'b0, 32'h8, 32'h0, 2'd0, 1'b1);
    txn("rd_half0_u", 1'b0, 32'h8, 32'h0, 2'd1, 1'b0);
    txn("half_misalign", 1'b0, 32'h3, 32'h0, 2'd1, 1'b0);
    txn("width_illegal", 1'b0, 32'h4, 32'h0, 2'd3, 1'b0);
    txn("word_misalign_wr", 1'b1, 32'h6, 32'h1234_5678, 2'd2, 1'b0);
    s_err = 1'b1;
    txn("bus_err_rd", 1'b0, 32'h8, 32'h0, 2'd2, 1'b0);
    txn("bus_err_wr", 1'b1, 32'h8, 32'h5555_AAAA, 2'd2, 1'b0);
    s_err = 1'b0;
    s_wait = 2;
    txn("wait2_rd", 1'b0, 32'h8, 32'h0, 2'd2, 1'b0);
    s_wait = 0;

`ifdef MINIBUS_MASTER_TIMEOUT_EN
    s_en = 1'b0;
    txn("timeout_rd", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    s_en = 1'b1;
    txn("after_timeout", 1'b0, 32'h4, 32'h0, 2'd2, 1'b0);
`endif

    // Reset in the middle of REQ with a slave that never answers.
    s_en = 1'b0;
    @(negedge clk);
    core_req_valid = 1'b1; core_wen = 1'b0; core_addr = 32'h0; core_width = 2'd2;
    @(posedge clk);
    #1;
    core_req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid ren_before", 32'(bus_ren), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid ren_after", 32'(bus_ren), 32'd0);
    check("rst_mid wen_after", 32'(bus_wen), 32'd0);
    d = 32'(mon_resp);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid no_resp", 32'(mon_resp) - d, 32'd0);
    check("rst_mid ready", 32'(core_req_ready), 32'd1);
    s_en = 1'b1;

    for (int n = 0; n < 40; n++) begin
      s_wait = $urandom_range(0, 2);
      s_err  = ($urandom_range(0, 9) == 0);
      txn("rand", 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    s_err = 1'b0;
    s_wait = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
